// File: rtl/bh_fpga_asic_config.sv
// Host config bridge: latches wire-in 0x01 on trigger-in 0x40 bits, streams the set to the ASIC.
// Define CFG_CHECKSUM_EN to append a mod-2^STREAM_W sum word after the 39 config words.
module bh_fpga_asic_config #(
    parameter int STREAM_W       = 16,
    parameter int CUT_DEPTH      = 15,
    parameter int RESET_DONE_CYC = 16
) (
    input  logic                sys_clk,
    input  logic                reset_n,
    input  logic [31:0]         ep01_wire,
    input  logic [31:0]         ep40_trig,
    output logic [31:0]         ep60_trig,
    output logic                asic_reset_n,
    output logic                stream_valid,
    output logic [STREAM_W-1:0] stream_data,
    input  logic                stream_ready,
    output logic [7:0]          led
);

    localparam int NSCAL = 9;
    localparam int NDATA = NSCAL + 2 * CUT_DEPTH;
`ifdef CFG_CHECKSUM_EN
    localparam int NWORDS = NDATA + 1;
`else
    localparam int NWORDS = NDATA;
`endif
    localparam int IW = $clog2(NWORDS + 1);
    localparam int PW = $clog2(CUT_DEPTH + 1);
    localparam int CW = $clog2(RESET_DONE_CYC + 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CONFIG = 3'd1,
        SEND   = 3'd2,
        SENT   = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [STREAM_W-1:0] scal_q [NSCAL];
    logic [STREAM_W-1:0] scal_d [NSCAL];
    logic [STREAM_W-1:0] cut1_q [CUT_DEPTH];
    logic [STREAM_W-1:0] cut1_d [CUT_DEPTH];
    logic [STREAM_W-1:0] cut2_q [CUT_DEPTH];
    logic [STREAM_W-1:0] cut2_d [CUT_DEPTH];
    logic [PW-1:0]       ptr1_q, ptr1_d;
    logic [PW-1:0]       ptr2_q, ptr2_d;
    logic                ovf1_q, ovf1_d;
    logic                ovf2_q, ovf2_d;
    logic                valid_q, valid_d;
    logic [STREAM_W-1:0] data_q, data_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic                ep60_q, ep60_d;
    logic [CW-1:0]       rcnt_q, rcnt_d;
    logic                rdone_q, rdone_d;
    logic [1:0]          arst_q, arst_d;
`ifdef CFG_CHECKSUM_EN
    logic [STREAM_W-1:0] sum_q, sum_d;
`endif

    logic                trig_hit;
    int                  trig_bit;
    logic                cfg_ok;
    logic [STREAM_W-1:0] wval;
    logic [IW-1:0]       sel_idx;
    logic [STREAM_W-1:0] sel_word;

    assign wval = ep01_wire[STREAM_W-1:0];
    assign cfg_ok = (state_q == CONFIG) || (state_q == SENT);

    // Only the lowest set trigger bit is acted on in a given cycle.
    always_comb begin
        trig_hit = 1'b0;
        trig_bit = 0;
        for (int i = 31; i >= 0; i--) begin
            if (ep40_trig[i]) begin
                trig_hit = 1'b1;
                trig_bit = i;
            end
        end
    end

    assign sel_idx = (state_q == SEND) ? idx_q + 1'b1 : '0;

    // Cut entries at or beyond the write pointer read back as zero.
    always_comb begin
        int k;
        k = int'(sel_idx);
        sel_word = '0;
        for (int j = 0; j < NSCAL; j++) begin
            if (k == j) sel_word = scal_q[j];
        end
        for (int j = 0; j < CUT_DEPTH; j++) begin
            if (k == NSCAL + j && j < int'(ptr1_q)) sel_word = cut1_q[j];
            if (k == NSCAL + CUT_DEPTH + j && j < int'(ptr2_q)) sel_word = cut2_q[j];
        end
`ifdef CFG_CHECKSUM_EN
        if (k == NDATA) sel_word = sum_q + data_q;
`endif
    end

    always_comb begin
        state_d = state_q;
        scal_d  = scal_q;
        cut1_d  = cut1_q;
        cut2_d  = cut2_q;
        ptr1_d  = ptr1_q;
        ptr2_d  = ptr2_q;
        ovf1_d  = ovf1_q;
        ovf2_d  = ovf2_q;
        valid_d = valid_q;
        data_d  = data_q;
        idx_d   = idx_q;
        ep60_d  = 1'b0;
        rcnt_d  = rcnt_q;
        rdone_d = rdone_q;
        arst_d  = {arst_q[0], 1'b1};
`ifdef CFG_CHECKSUM_EN
        sum_d   = sum_q;
`endif

        if (!rdone_q) begin
            rcnt_d = rcnt_q + 1'b1;
            if (rcnt_q == CW'(RESET_DONE_CYC - 1)) begin
                rdone_d = 1'b1;
                ep60_d  = 1'b1;
            end
        end

        if (state_q == SEND) begin
            if (stream_ready) begin
`ifdef CFG_CHECKSUM_EN
                sum_d = sum_q + data_q;
`endif
                if (idx_q == IW'(NWORDS - 1)) begin
                    valid_d = 1'b0;
                    ep60_d  = 1'b1;
                    idx_d   = '0;
                    state_d = SENT;
                end else begin
                    idx_d  = idx_q + 1'b1;
                    data_d = sel_word;
                end
            end
        end else if (trig_hit) begin
            if (trig_bit == 0) begin
                if (ep01_wire == 32'd1) begin
                    state_d = CONFIG;
                    ptr1_d  = '0;
                    ptr2_d  = '0;
                    ovf1_d  = 1'b0;
                    ovf2_d  = 1'b0;
                end else if (ep01_wire == 32'd2) begin
                    if (state_q == SENT) state_d = DONE;
                end else if (ep01_wire == 32'd0) begin
                    state_d = IDLE;
                end
            end else if (trig_bit <= NSCAL) begin
                if (cfg_ok) begin
                    for (int j = 0; j < NSCAL; j++) begin
                        if (trig_bit == j + 1) scal_d[j] = wval;
                    end
                end
            end else if (trig_bit == 10) begin
                if (ptr1_q == PW'(CUT_DEPTH)) begin
                    ovf1_d = 1'b1;
                end else begin
                    for (int j = 0; j < CUT_DEPTH; j++) begin
                        if (j == int'(ptr1_q)) cut1_d[j] = wval;
                    end
                    ptr1_d = ptr1_q + 1'b1;
                end
            end else if (trig_bit == 11) begin
                if (ptr2_q == PW'(CUT_DEPTH)) begin
                    ovf2_d = 1'b1;
                end else begin
                    for (int j = 0; j < CUT_DEPTH; j++) begin
                        if (j == int'(ptr2_q)) cut2_d[j] = wval;
                    end
                    ptr2_d = ptr2_q + 1'b1;
                end
            end else if (trig_bit == 31) begin
                if (cfg_ok) begin
                    state_d = SEND;
                    valid_d = 1'b1;
                    data_d  = sel_word;
                    idx_d   = '0;
`ifdef CFG_CHECKSUM_EN
                    sum_d   = '0;
`endif
                end
            end
        end
    end

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            scal_q  <= '{default: '0};
            cut1_q  <= '{default: '0};
            cut2_q  <= '{default: '0};
            ptr1_q  <= '0;
            ptr2_q  <= '0;
            ovf1_q  <= 1'b0;
            ovf2_q  <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
            idx_q   <= '0;
            ep60_q  <= 1'b0;
            rcnt_q  <= '0;
            rdone_q <= 1'b0;
            arst_q  <= '0;
`ifdef CFG_CHECKSUM_EN
            sum_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            scal_q  <= scal_d;
            cut1_q  <= cut1_d;
            cut2_q  <= cut2_d;
            ptr1_q  <= ptr1_d;
            ptr2_q  <= ptr2_d;
            ovf1_q  <= ovf1_d;
            ovf2_q  <= ovf2_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
            ep60_q  <= ep60_d;
            rcnt_q  <= rcnt_d;
            rdone_q <= rdone_d;
            arst_q  <= arst_d;
`ifdef CFG_CHECKSUM_EN
            sum_q   <= sum_d;
`endif
        end
    end

    assign ep60_trig    = {31'b0, ep60_q};
    assign asic_reset_n = arst_q[1];
    assign stream_valid = valid_q;
    assign stream_data  = data_q;
    assign led          = {4'b0, ovf1_q | ovf2_q, state_q};

endmodule

// File: tb/tb_bh_fpga_asic_config.sv
// Scoreboard bench for bh_fpga_asic_config: model predicts streamed words,
// a negedge monitor pops and compares every handshake.
module tb_bh_fpga_asic_config;

    localparam int SW = 16;
    localparam int NDATA = 39;
`ifdef CFG_CHECKSUM_EN
    localparam int NWORDS = NDATA + 1;
`else
    localparam int NWORDS = NDATA;
`endif

    logic          sys_clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [31:0]   ep01_wire = '0;
    logic [31:0]   ep40_trig = '0;
    logic [31:0]   ep60_trig;
    logic          asic_reset_n;
    logic          stream_valid;
    logic [SW-1:0] stream_data;
    logic          stream_ready = 1'b0;
    logic [7:0]    led;

    bh_fpga_asic_config dut (
        .sys_clk      (sys_clk),
        .reset_n      (reset_n),
        .ep01_wire    (ep01_wire),
        .ep40_trig    (ep40_trig),
        .ep60_trig    (ep60_trig),
        .asic_reset_n (asic_reset_n),
        .stream_valid (stream_valid),
        .stream_data  (stream_data),
        .stream_ready (stream_ready),
        .led          (led)
    );

    always #5 sys_clk = ~sys_clk;

    int checks = 0;
    int failures = 0;

    // reference model: states 0 idle,1 config,2 send,3 sent,4 done
    int          mst;
    logic [15:0] mscal [9];
    logic [15:0] mc1 [15];
    logic [15:0] mc2 [15];
    int          mp1, mp2;
    bit          movf1, movf2;
    logic [15:0] exp_q [$];

    int ep60_cnt = 0;
    int words_done = 0;
    int valid_cycles = 0;
    int rmode_g = 0;
    int abort_g = -1;
    bit stall_pend = 0;
    logic [15:0] stall_data;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_led(string name);
        logic [7:0] e;
        e = {4'b0, movf1 | movf2, 3'(mst)};
        chk(name, {24'b0, led}, {24'b0, e});
    endtask

    task automatic model_reset();
        mst = 0;
        mp1 = 0;
        mp2 = 0;
        movf1 = 0;
        movf2 = 0;
        for (int i = 0; i < 9; i++) mscal[i] = '0;
        for (int i = 0; i < 15; i++) begin
            mc1[i] = '0;
            mc2[i] = '0;
        end
        exp_q.delete();
    endtask

    task automatic model_load();
        logic [15:0] s;
        s = '0;
        for (int i = 0; i < 9; i++) begin
            exp_q.push_back(mscal[i]);
            s += mscal[i];
        end
        for (int i = 0; i < 15; i++) begin
            exp_q.push_back(mc1[i]);
            s += mc1[i];
        end
        for (int i = 0; i < 15; i++) begin
            exp_q.push_back(mc2[i]);
            s += mc2[i];
        end
`ifdef CFG_CHECKSUM_EN
        exp_q.push_back(s);
`endif
    endtask

    task automatic model_trig(logic [31:0] mask, logic [31:0] v);
        int b;
        b = -1;
        for (int i = 31; i >= 0; i--) if (mask[i]) b = i;
        if (b < 0 || mst == 2) return;
        if (b == 0) begin
            if (v == 1) begin
                mst = 1;
                mp1 = 0;
                mp2 = 0;
                movf1 = 0;
                movf2 = 0;
                for (int i = 0; i < 15; i++) begin
                    mc1[i] = '0;
                    mc2[i] = '0;
                end
            end else if (v == 2) begin
                if (mst == 3) mst = 4;
            end else if (v == 0) begin
                mst = 0;
            end
        end else if (b <= 9) begin
            if (mst == 1 || mst == 3) mscal[b-1] = v[15:0];
        end else if (b == 10) begin
            if (mp1 == 15) movf1 = 1;
            else begin
                mc1[mp1] = v[15:0];
                mp1++;
            end
        end else if (b == 11) begin
            if (mp2 == 15) movf2 = 1;
            else begin
                mc2[mp2] = v[15:0];
                mp2++;
            end
        end else if (b == 31) begin
            if (mst == 1 || mst == 3) begin
                model_load();
                mst = 2;
            end
        end
    endtask

    task automatic release_chk(string tag);
        int n;
        n = 0;
        reset_n = 1'b1;
        while (n < 100) begin
            @(posedge sys_clk);
            #1;
            n++;
            if (ep60_trig[0]) break;
        end
        chk({tag, "_ready_delay"}, n, 16);
        chk({tag, "_asic_reset_n"}, {31'b0, asic_reset_n}, 1);
        @(posedge sys_clk);
        #1;
        chk({tag, "_ready_one_cycle"}, {31'b0, ep60_trig[0]}, 0);
        chk({tag, "_valid"}, {31'b0, stream_valid}, 0);
        chk_led({tag, "_led"});
    endtask

    task automatic run_send();
        int n;
        int c0;
        int vc0;
        n = 0;
        c0 = ep60_cnt;
        vc0 = valid_cycles;
        words_done = 0;
        stream_ready = (rmode_g == 0);
        while (n < 1000) begin
            @(posedge sys_clk);
            #1;
            n++;
            if (abort_g >= 0 && words_done == abort_g) begin
                reset_n = 1'b0;
                #1;
                chk("abort_valid", {31'b0, stream_valid}, 0);
                chk("abort_led", {24'b0, led}, 0);
                chk("abort_asic_reset", {31'b0, asic_reset_n}, 0);
                model_reset();
                stream_ready = 1'b0;
                abort_g = -1;
                return;
            end
            if (ep60_cnt != c0) break;
            case (rmode_g)
                0: stream_ready = 1'b1;
                1: stream_ready = n[0];
                default: stream_ready = 1'($urandom_range(0, 1));
            endcase
        end
        chk("send_in_time", {31'b0, n < 1000}, 1);
        chk("words_consumed", exp_q.size(), 0);
        chk("done_pulses", ep60_cnt - c0, 1);
        if (rmode_g == 0) chk("no_bubble", valid_cycles - vc0, NWORDS);
        mst = 3;
        chk_led("sent_led");
        stream_ready = 1'b0;
    endtask

    task automatic send_trig(logic [31:0] mask, logic [31:0] v);
        model_trig(mask, v);
        ep01_wire = v;
        ep40_trig = mask;
        @(posedge sys_clk);
        #1;
        ep40_trig = '0;
        if (mst == 2) run_send();
    endtask

    task automatic trig(int b, logic [31:0] v);
        send_trig(32'd1 << b, v);
    endtask

    task automatic directed_load();
        logic [15:0] sc [9];
        logic [15:0] cl [14];
        sc = '{0, 200, 500, 1, 5, 578, 0, 0, 0};
        cl = '{256, 17, 171, 342, 342, 342, 342, 342,
               342, 342, 342, 342, 342, 496};
        trig(0, 1);
        chk_led("config_led");
        for (int i = 0; i < 9; i++) trig(i + 1, {16'hbeef, sc[i]});
        for (int i = 0; i < 14; i++) trig(10, {16'h0, cl[i]});
        for (int i = 0; i < 14; i++) trig(11, {16'h0, cl[i]});
    endtask

    task automatic monitor();
        forever begin
            @(negedge sys_clk);
            if (!reset_n) begin
                stall_pend = 0;
            end else begin
                if (ep60_trig != 0) begin
                    ep60_cnt++;
                    chk("ep60_upper_zero", {1'b0, ep60_trig[31:1]}, 0);
                end
                if (stream_valid) valid_cycles++;
                if (stall_pend) begin
                    chk("stall_valid_held", {31'b0, stream_valid}, 1);
                    chk("stall_data_held", {16'b0, stream_data}, {16'b0, stall_data});
                end
                stall_pend = 0;
                if (stream_valid && stream_ready) begin
                    chk("scoreboard_nonempty", {31'b0, exp_q.size() != 0}, 1);
                    if (exp_q.size() != 0) begin
                        chk("stream_word", {16'b0, stream_data}, {16'b0, exp_q.pop_front()});
                    end
                    words_done++;
                end else if (stream_valid) begin
                    stall_pend = 1;
                    stall_data = stream_data;
                end
            end
        end
    endtask

    task automatic stimulus();
        int c0;
        model_reset();
        repeat (3) @(posedge sys_clk);
        #1;
        chk("reset_asic_reset_n", {31'b0, asic_reset_n}, 0);
        chk("reset_valid", {31'b0, stream_valid}, 0);
        chk("reset_led", {24'b0, led}, 0);
        chk("reset_ep60", ep60_trig, 0);
        release_chk("por");

        trig(5, 7);
        trig(31, 0);
        stream_ready = 1'b1;
        repeat (20) @(posedge sys_clk);
        #1;
        chk("idle_no_stream", {31'b0, stream_valid}, 0);
        chk_led("idle_led");
        stream_ready = 1'b0;

        rmode_g = 0;
        directed_load();
        trig(31, 0);
        trig(0, 2);
        chk_led("done_led");
        chk("done_led_value", {24'b0, led}, 4);

        rmode_g = 1;
        directed_load();
        trig(31, 0);

        trig(0, 1);
        for (int i = 0; i < 16; i++) trig(10, 32'h1000 + i);
        chk_led("ovf_led");
        chk("ovf_led3", {31'b0, led[3]}, 1);
        rmode_g = 2;
        trig(31, 0);
        trig(0, 1);
        chk("ovf_cleared", {31'b0, led[3]}, 0);
        trig(31, 0);

        for (int it = 0; it < 6; it++) begin
            trig(0, 1);
            for (int k = 0; k < 30; k++) begin
                int b;
                logic [31:0] m;
                b = $urandom_range(1, 11);
                m = 32'd1 << b;
                if ($urandom_range(0, 3) == 0) m |= 32'd1 << $urandom_range(b, 30);
                send_trig(m, $urandom);
            end
            rmode_g = $urandom_range(0, 2);
            trig(31, 0);
            trig(3, $urandom);
            trig(31, 0);
            trig(0, $urandom_range(0, 2));
            chk_led("random_led");
        end

        rmode_g = 0;
        abort_g = 10;
        directed_load();
        trig(31, 0);
        repeat (3) @(posedge sys_clk);
        #1;
        c0 = ep60_cnt;
        release_chk("abort");
        repeat (40) @(posedge sys_clk);
        #1;
        chk("abort_only_ready_pulse", ep60_cnt - c0, 1);
        chk("abort_idle_valid", {31'b0, stream_valid}, 0);
    endtask

    initial begin
        fork
            monitor();
            stimulus();
        join_any
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
